// File: rtl/crc_bus_initiator.sv
// Bus initiator for the CRC32 peripheral: programs poly/config/enable, streams bytes
// into the data register, disables the engine and reads back the result.
module crc_bus_initiator #(
  parameter logic [31:0] POLY_DEFAULT = 32'h04C11DB7,
  parameter int unsigned BYTE_GAP     = 1,
  parameter int unsigned READ_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  cfg,
  input  logic [31:0] poly,
  input  logic        poly_sel,
  input  logic        s_valid,
  input  logic [7:0]  s_data,
  input  logic        s_last,
  output logic        s_ready,
  output logic        busy,
  output logic [31:0] result,
  output logic        result_valid,
  output logic        timeout_err,
  output logic [5:0]  address,
  output logic [31:0] wdata,
  output logic [1:0]  data_write_n,
  output logic [1:0]  data_read_n,
  input  logic [31:0] rdata,
  input  logic        data_ready
);

  localparam int unsigned CNT_W = 8;

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_WR_POLY = 4'd1;
  localparam logic [3:0] S_WR_CFG  = 4'd2;
  localparam logic [3:0] S_WR_EN   = 4'd3;
  localparam logic [3:0] S_STREAM  = 4'd4;
  localparam logic [3:0] S_WR_BYTE = 4'd5;
  localparam logic [3:0] S_GAP     = 4'd6;
  localparam logic [3:0] S_WR_DIS  = 4'd7;
  localparam logic [3:0] S_RD      = 4'd8;
  localparam logic [3:0] S_DONE    = 4'd9;

  localparam logic [5:0] A_EN   = 6'h00;
  localparam logic [5:0] A_CFG  = 6'h04;
  localparam logic [5:0] A_DATA = 6'h08;
  localparam logic [5:0] A_RES  = 6'h0C;
  localparam logic [5:0] A_POLY = 6'h10;

  localparam logic [1:0] W_NONE = 2'b11;
  localparam logic [1:0] W_8    = 2'b00;
  localparam logic [1:0] W_32   = 2'b10;
  localparam logic [1:0] R_NONE = 2'b11;
  localparam logic [1:0] R_32   = 2'b10;

  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(BYTE_GAP - 1);
  localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(READ_TIMEOUT - 1);

  logic [3:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [7:0]       cfg_q, cfg_nxt;
  logic [31:0]      poly_q, poly_nxt;
  logic             last_q, last_nxt;

  logic        s_ready_nxt, busy_nxt, result_valid_nxt, timeout_nxt;
  logic [31:0] result_nxt, wdata_nxt;
  logic [5:0]  address_nxt;
  logic [1:0]  wn_nxt, rn_nxt;

  // Bus outputs are computed for the state being entered so they register in step with it.
  always_comb begin
    state_nxt        = state;
    cnt_nxt          = cnt;
    cfg_nxt          = cfg_q;
    poly_nxt         = poly_q;
    last_nxt         = last_q;
    result_nxt       = result;
    timeout_nxt      = timeout_err;
    s_ready_nxt      = 1'b0;
    result_valid_nxt = 1'b0;
    address_nxt      = 6'h00;
    wdata_nxt        = 32'h0;
    wn_nxt           = W_NONE;
    rn_nxt           = R_NONE;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt   = S_WR_POLY;
          cfg_nxt     = cfg;
          poly_nxt    = poly_sel ? poly : POLY_DEFAULT;
          timeout_nxt = 1'b0;
          address_nxt = A_POLY;
          wdata_nxt   = poly_nxt;
          wn_nxt      = W_32;
        end
      end
      S_WR_POLY: begin
        state_nxt   = S_WR_CFG;
        address_nxt = A_CFG;
        wdata_nxt   = {24'h0, cfg_q};
        wn_nxt      = W_8;
      end
      S_WR_CFG: begin
        state_nxt   = S_WR_EN;
        address_nxt = A_EN;
        wdata_nxt   = 32'd1;
        wn_nxt      = W_8;
      end
      S_WR_EN: begin
        state_nxt   = S_STREAM;
        s_ready_nxt = 1'b1;
      end
      S_STREAM: begin
        if (s_valid && s_ready) begin
          state_nxt   = S_WR_BYTE;
          last_nxt    = s_last;
          address_nxt = A_DATA;
          wdata_nxt   = {24'h0, s_data};
          wn_nxt      = W_8;
        end else begin
          s_ready_nxt = 1'b1;
        end
      end
      S_WR_BYTE: begin
        if (last_q) begin
          state_nxt   = S_WR_DIS;
          address_nxt = A_EN;
          wdata_nxt   = 32'd0;
          wn_nxt      = W_8;
        end else if (BYTE_GAP == 0) begin
          state_nxt   = S_STREAM;
          s_ready_nxt = 1'b1;
        end else begin
          state_nxt = S_GAP;
          cnt_nxt   = '0;
        end
      end
      S_GAP: begin
        if (cnt == GAP_LAST) begin
          state_nxt   = S_STREAM;
          s_ready_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_WR_DIS: begin
        state_nxt   = S_RD;
        cnt_nxt     = '0;
        address_nxt = A_RES;
        rn_nxt      = R_32;
      end
      S_RD: begin
        // Read held until data_ready; gives up after READ_TIMEOUT read cycles.
        if (data_ready) begin
          state_nxt        = S_DONE;
          result_nxt       = rdata;
          result_valid_nxt = 1'b1;
        end else if (cnt == RD_LAST) begin
          state_nxt   = S_IDLE;
          timeout_nxt = 1'b1;
        end else begin
          cnt_nxt     = cnt + CNT_W'(1);
          address_nxt = A_RES;
          rn_nxt      = R_32;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    busy_nxt = (state_nxt != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      cnt          <= '0;
      cfg_q        <= 8'h0;
      poly_q       <= 32'h0;
      last_q       <= 1'b0;
      s_ready      <= 1'b0;
      busy         <= 1'b0;
      result       <= 32'h0;
      result_valid <= 1'b0;
      timeout_err  <= 1'b0;
      address      <= 6'h00;
      wdata        <= 32'h0;
      data_write_n <= W_NONE;
      data_read_n  <= R_NONE;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      cfg_q        <= cfg_nxt;
      poly_q       <= poly_nxt;
      last_q       <= last_nxt;
      s_ready      <= s_ready_nxt;
      busy         <= busy_nxt;
      result       <= result_nxt;
      result_valid <= result_valid_nxt;
      timeout_err  <= timeout_nxt;
      address      <= address_nxt;
      wdata        <= wdata_nxt;
      data_write_n <= wn_nxt;
      data_read_n  <= rn_nxt;
    end
  end

endmodule

// File: tb/tb_crc_bus_initiator.sv
// Bench for crc_bus_initiator: behavioural CRC peripheral on the bus side, randomized
// byte streams, and a bit-serial CRC32 reference computed from the submitted bytes.
module tb_crc_bus_initiator;

  localparam logic [31:0] POLY_DEF     = 32'h04C11DB7;
  localparam int          BYTE_GAP     = 1;
  localparam int          READ_TIMEOUT = 255;

  typedef logic [7:0] bq_t[$];
  typedef bit vq_t[$];
  typedef struct {
    int          cyc;
    logic [5:0]  addr;
    logic [31:0] data;
    logic [1:0]  wn;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  cfg = 8'h0;
  logic [31:0] poly = 32'h0;
  logic        poly_sel = 1'b0;
  logic        s_valid = 1'b0;
  logic [7:0]  s_data = 8'h0;
  logic        s_last = 1'b0;
  logic        s_ready, busy, result_valid, timeout_err;
  logic [31:0] result, wdata;
  logic [5:0]  address;
  logic [1:0]  data_write_n, data_read_n;
  logic [31:0] rdata = 32'h0;
  logic        data_ready = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  int  cyc = 0;
  wr_t wr_q[$];
  int  sr_rise_q[$];
  int  proto_err = 0, rv_count = 0, rd_total = 0, rd_run = 0;
  int  last_rd_cyc = 0, last_rv_cyc = 0;
  logic [31:0] rv_result = 32'h0;
  logic sready_d = 1'b0;
  int  stall_cycles = 0;
  bit  never_ready = 1'b0, noise_en = 1'b0, force_en = 1'b0;
  logic [31:0] force_val = 32'h0;
  logic [31:0] exp_last = 32'h0;

  crc_bus_initiator #(
    .POLY_DEFAULT(POLY_DEF),
    .BYTE_GAP(BYTE_GAP),
    .READ_TIMEOUT(READ_TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg(cfg), .poly(poly), .poly_sel(poly_sel),
    .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready), .busy(busy),
    .result(result), .result_valid(result_valid), .timeout_err(timeout_err),
    .address(address), .wdata(wdata), .data_write_n(data_write_n), .data_read_n(data_read_n),
    .rdata(rdata), .data_ready(data_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // MSB-first CRC32 with optional reflection, init and final xor as selected by cfg.
  function automatic logic [31:0] crc_model(input logic [31:0] p, input logic [7:0] c, input bq_t b);
    logic [31:0] crc, r;
    logic [7:0]  d, dr;
    crc = c[2] ? 32'hFFFFFFFF : 32'h0;
    foreach (b[k]) begin
      d = b[k];
      for (int j = 0; j < 8; j++) dr[j] = d[7-j];
      if (c[0]) d = dr;
      crc = crc ^ {d, 24'h0};
      for (int j = 0; j < 8; j++) crc = crc[31] ? ((crc << 1) ^ p) : (crc << 1);
    end
    for (int j = 0; j < 32; j++) r[j] = crc[31-j];
    if (c[0]) crc = r;
    if (c[1]) crc = crc ^ 32'hFFFFFFFF;
    return crc;
  endfunction

  // Peripheral view: replay every write seen on the bus to find the current job's inputs.
  function automatic logic [31:0] periph_crc();
    logic [31:0] p = POLY_DEF;
    logic [7:0]  c = 8'h0;
    bq_t b;
    foreach (wr_q[k]) begin
      case (wr_q[k].addr)
        6'h10: p = wr_q[k].data;
        6'h04: c = wr_q[k].data[7:0];
        6'h00: if (wr_q[k].data[0]) b.delete();
        6'h08: b.push_back(wr_q[k].data[7:0]);
        default: ;
      endcase
    end
    return crc_model(p, c, b);
  endfunction

  // Index of first trace entry differing from the expected job sequence; -2 on count, -1 if equal.
  function automatic int trace_diff(input int k0, input logic [7:0] c, input logic [31:0] p, input bq_t b);
    wr_t e[$];
    e.push_back('{0, 6'h10, p, 2'b10});
    e.push_back('{0, 6'h04, {24'h0, c}, 2'b00});
    e.push_back('{0, 6'h00, 32'd1, 2'b00});
    foreach (b[k]) e.push_back('{0, 6'h08, {24'h0, b[k]}, 2'b00});
    e.push_back('{0, 6'h00, 32'd0, 2'b00});
    if (wr_q.size() - k0 != e.size()) return -2;
    foreach (e[k]) begin
      if (wr_q[k0+k].addr !== e[k].addr || wr_q[k0+k].data !== e[k].data || wr_q[k0+k].wn !== e[k].wn)
        return k;
    end
    return -1;
  endfunction

  function automatic int min_byte_space(input int k0);
    int m = 1000, prev = -1;
    for (int k = k0; k < wr_q.size(); k++) begin
      if (wr_q[k].addr == 6'h08) begin
        if (prev >= 0 && wr_q[k].cyc - prev < m) m = wr_q[k].cyc - prev;
        prev = wr_q[k].cyc;
      end
    end
    return m;
  endfunction

  function automatic int count_addr(input int k0, input logic [5:0] a);
    int n = 0;
    for (int k = k0; k < wr_q.size(); k++) if (wr_q[k].addr == a) n++;
    return n;
  endfunction

  // Bus monitor and peripheral responder.
  always @(negedge clk) begin
    if (data_write_n != 2'b11) wr_q.push_back('{cyc, address, wdata, data_write_n});
    if (data_write_n != 2'b11 && data_read_n != 2'b11) proto_err++;
    if (!(data_write_n inside {2'b11, 2'b00, 2'b10}) || !(data_read_n inside {2'b11, 2'b10})) proto_err++;
    if (data_read_n == 2'b10 && address != 6'h0C) proto_err++;
    if (s_ready && !sready_d) sr_rise_q.push_back(cyc);
    sready_d = s_ready;
    if (result_valid) begin
      rv_count++;
      last_rv_cyc = cyc;
      rv_result = result;
    end
    if (data_read_n == 2'b10) begin
      rd_total++;
      rd_run++;
      last_rd_cyc = cyc;
      if (!never_ready && rd_run > stall_cycles) begin
        data_ready = 1'b1;
        rdata = force_en ? force_val : periph_crc();
      end else begin
        data_ready = 1'b0;
        rdata = $urandom;
      end
    end else begin
      rd_run = 0;
      data_ready = noise_en ? 1'($urandom_range(1)) : 1'b0;
      rdata = $urandom;
    end
  end

  task automatic run_job(input logic [7:0] c, input logic [31:0] p, input logic ps, input bq_t b,
                         input vq_t vpat, input int valid_pct, input bit poke_start,
                         output int c0, output bit ok);
    int  i = 0, guard = 0, pidx = 1;
    int  n = b.size();
    bit  acc;
    @(negedge clk);
    c0 = cyc;
    start = 1'b1; cfg = c; poly = p; poly_sel = ps;
    s_valid = (vpat.size() > 0) ? vpat[0] : ($urandom_range(99) < valid_pct);
    s_data = b[0];
    s_last = (n == 1);
    acc = s_valid && s_ready;
    @(negedge clk);
    start = 1'b0;
    while (guard < 3000) begin
      if (acc) i++;
      if (i == n) break;
      if (!(s_valid && !acc)) begin
        if (pidx < vpat.size()) begin
          s_valid = vpat[pidx];
          pidx++;
        end else begin
          s_valid = ($urandom_range(99) < valid_pct);
        end
        s_data = s_valid ? b[i] : 8'($urandom);
        s_last = s_valid ? (i == n - 1) : 1'($urandom_range(1));
      end
      // Captured inputs are scrambled and start pokes must be ignored once busy.
      cfg = 8'($urandom); poly = $urandom; poly_sel = 1'($urandom_range(1));
      start = poke_start ? 1'($urandom_range(1)) : 1'b0;
      acc = s_valid && s_ready;
      @(negedge clk);
      guard++;
    end
    s_valid = 1'b0; s_last = 1'b0; start = 1'b0;
    ok = (i == n);
    guard = 0;
    while (busy && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    ok = ok && !busy;
    @(negedge clk);
  endtask

  task automatic test_reset();
    vectors++;
    if ({address, wdata, data_write_n, data_read_n} !== {6'h00, 32'h0, 2'b11, 2'b11}) begin
      miscompares++;
      $display("FAIL reset_bus: got addr=%h wdata=%h wn=%b rn=%b, want 00/00000000/11/11", address, wdata, data_write_n, data_read_n);
    end
    vectors++;
    if ({s_ready, busy, result_valid, timeout_err} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_status: got %b, want 0000", {s_ready, busy, result_valid, timeout_err});
    end
    vectors++;
    if (result !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_result: got %h, want 00000000", result);
    end
  endtask

  task automatic test_known_vector();
    bq_t b = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    vq_t vp;
    int  k0 = wr_q.size(), s0 = sr_rise_q.size(), rv0 = rv_count, c0, d;
    bit  ok;
    run_job(8'h07, $urandom, 1'b0, b, vp, 100, 1'b0, c0, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL kv_complete: job did not finish, want finished"); end
    d = trace_diff(k0, 8'h07, POLY_DEF, b);
    vectors++;
    if (d !== -1) begin miscompares++; $display("FAIL kv_trace: first bad entry %0d, want -1", d); end
    vectors++;
    if (wr_q.size() < k0 + 3 || wr_q[k0].cyc != c0 + 1 || wr_q[k0+1].cyc != c0 + 2 || wr_q[k0+2].cyc != c0 + 3) begin
      miscompares++;
      $display("FAIL kv_setup_timing: setup writes not at cycles 1/2/3 after start (start cyc %0d)", c0);
    end
    vectors++;
    if (sr_rise_q.size() <= s0 || sr_rise_q[s0] != c0 + 4) begin
      miscompares++;
      $display("FAIL kv_sready_cycle: got %0d, want %0d", (sr_rise_q.size() > s0) ? sr_rise_q[s0] : -1, c0 + 4);
    end
    vectors++;
    if (result !== 32'hCBF43926 || result !== crc_model(POLY_DEF, 8'h07, b)) begin
      miscompares++;
      $display("FAIL kv_result: got %h, want cbf43926", result);
    end
    vectors++;
    if (rv_count - rv0 != 1 || timeout_err !== 1'b0) begin
      miscompares++;
      $display("FAIL kv_pulse: got %0d pulses timeout_err=%b, want 1 pulse timeout_err=0", rv_count - rv0, timeout_err);
    end
    exp_last = 32'hCBF43926;
  endtask

  task automatic test_backpressure();
    bq_t b = '{8'hA5, 8'h3C};
    vq_t vp = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [31:0] p = $urandom;
    logic [7:0]  c = 8'($urandom_range(7));
    int  k0 = wr_q.size(), rv0 = rv_count, c0, d, sp;
    bit  ok;
    run_job(c, p, 1'b1, b, vp, 40, 1'b0, c0, ok);
    d = trace_diff(k0, c, p, b);
    vectors++;
    if (!ok || d !== -1) begin miscompares++; $display("FAIL bp_trace: ok=%b first bad entry %0d, want 1/-1", ok, d); end
    sp = min_byte_space(k0);
    vectors++;
    if (sp < 2 + BYTE_GAP) begin miscompares++; $display("FAIL bp_spacing: got %0d cycles, want >= %0d", sp, 2 + BYTE_GAP); end
    exp_last = crc_model(p, c, b);
    vectors++;
    if (result !== exp_last || rv_count - rv0 != 1) begin
      miscompares++;
      $display("FAIL bp_result: got %h pulses %0d, want %h pulses 1", result, rv_count - rv0, exp_last);
    end
  endtask

  task automatic test_read_stall();
    bq_t b;
    vq_t vp;
    int  rd0 = rd_total, rv0 = rv_count, c0;
    bit  ok;
    b.push_back(8'($urandom));
    stall_cycles = 10; force_en = 1'b1; force_val = 32'h12345678;
    run_job(8'h07, $urandom, 1'b0, b, vp, 100, 1'b0, c0, ok);
    stall_cycles = 0; force_en = 1'b0;
    vectors++;
    if (!ok || rd_total - rd0 != 11) begin
      miscompares++;
      $display("FAIL stall_read_cycles: got %0d, want 11", rd_total - rd0);
    end
    vectors++;
    if (result !== 32'h12345678 || rv_result !== 32'h12345678) begin
      miscompares++;
      $display("FAIL stall_result: got %h (at pulse %h), want 12345678", result, rv_result);
    end
    vectors++;
    if (rv_count - rv0 != 1 || last_rv_cyc != last_rd_cyc + 1) begin
      miscompares++;
      $display("FAIL stall_pulse: got %0d pulses at %0d, want 1 at %0d", rv_count - rv0, last_rv_cyc, last_rd_cyc + 1);
    end
    exp_last = 32'h12345678;
  endtask

  task automatic test_timeout();
    bq_t b = '{8'h5A, 8'hC3};
    vq_t vp;
    int  k0 = wr_q.size(), rd0 = rd_total, rv0 = rv_count, c0, d;
    bit  ok;
    never_ready = 1'b1;
    run_job(8'h01, 32'h1EDC6F41, 1'b1, b, vp, 80, 1'b0, c0, ok);
    never_ready = 1'b0;
    vectors++;
    if (!ok || rd_total - rd0 != READ_TIMEOUT) begin
      miscompares++;
      $display("FAIL to_read_cycles: got %0d, want %0d", rd_total - rd0, READ_TIMEOUT);
    end
    vectors++;
    if (timeout_err !== 1'b1 || busy !== 1'b0 || data_read_n !== 2'b11) begin
      miscompares++;
      $display("FAIL to_status: got err=%b busy=%b rn=%b, want 1/0/11", timeout_err, busy, data_read_n);
    end
    vectors++;
    if (result !== exp_last || rv_count != rv0) begin
      miscompares++;
      $display("FAIL to_result: got %h pulses %0d, want %h pulses 0", result, rv_count - rv0, exp_last);
    end
    d = trace_diff(k0, 8'h01, 32'h1EDC6F41, b);
    vectors++;
    if (d !== -1) begin miscompares++; $display("FAIL to_trace: first bad entry %0d, want -1", d); end
    b = '{8'h77};
    run_job(8'h04, $urandom, 1'b0, b, vp, 100, 1'b0, c0, ok);
    exp_last = crc_model(POLY_DEF, 8'h04, b);
    vectors++;
    if (!ok || timeout_err !== 1'b0 || result !== exp_last) begin
      miscompares++;
      $display("FAIL to_clear: got err=%b result=%h, want 0/%h", timeout_err, result, exp_last);
    end
  endtask

  task automatic test_reset_mid();
    bq_t b = '{8'h11, 8'h22, 8'h33, 8'h44};
    vq_t vp;
    int  k0 = wr_q.size(), n0, i = 0, guard = 0, c0, d;
    bit  acc, ok;
    logic [31:0] p;
    logic [7:0]  c;
    @(negedge clk);
    start = 1'b1; cfg = 8'h05; poly = 32'h1EDC6F41; poly_sel = 1'b1;
    @(negedge clk);
    start = 1'b0; s_valid = 1'b1; s_data = b[0]; s_last = 1'b0;
    while (count_addr(k0, 6'h08) < 2 && guard < 100) begin
      acc = s_valid && s_ready;
      @(negedge clk);
      guard++;
      if (acc) begin i++; s_data = b[i]; end
    end
    vectors++;
    if (guard >= 100) begin miscompares++; $display("FAIL rm_two_bytes: got %0d byte writes, want 2", count_addr(k0, 6'h08)); end
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if ({address, wdata, data_write_n, data_read_n, s_ready, busy, result_valid, timeout_err} !==
        {6'h00, 32'h0, 2'b11, 2'b11, 4'b0000} || result !== 32'h0) begin
      miscompares++;
      $display("FAIL rm_async_idle: got addr=%h wdata=%h wn=%b rn=%b st=%b res=%h, want idle/0",
               address, wdata, data_write_n, data_read_n, {s_ready, busy, result_valid, timeout_err}, result);
    end
    s_valid = 1'b0;
    n0 = wr_q.size();
    repeat (3) @(negedge clk);
    vectors++;
    if (wr_q.size() != n0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL rm_quiet: got %0d writes busy=%b during reset, want 0/0", wr_q.size() - n0, busy);
    end
    rst_n = 1'b1;
    exp_last = 32'h0;
    k0 = wr_q.size();
    p = $urandom; c = 8'($urandom_range(7));
    run_job(c, p, 1'b1, b, vp, 70, 1'b0, c0, ok);
    d = trace_diff(k0, c, p, b);
    exp_last = crc_model(p, c, b);
    vectors++;
    if (!ok || d !== -1 || result !== exp_last) begin
      miscompares++;
      $display("FAIL rm_replay: ok=%b bad entry %0d result=%h, want 1/-1/%h", ok, d, result, exp_last);
    end
  endtask

  task automatic test_random();
    noise_en = 1'b1;
    for (int j = 0; j < 8; j++) begin
      bq_t b;
      vq_t vp;
      int  n = $urandom_range(1, 6), k0 = wr_q.size(), rv0 = rv_count, c0, d, sp;
      logic [7:0]  c = 8'($urandom_range(7));
      logic [31:0] p = $urandom;
      logic        ps = 1'($urandom_range(1));
      bit  ok;
      for (int k = 0; k < n; k++) b.push_back(8'($urandom));
      stall_cycles = $urandom_range(0, 5);
      run_job(c, p, ps, b, vp, $urandom_range(30, 100), 1'b1, c0, ok);
      d = trace_diff(k0, c, ps ? p : POLY_DEF, b);
      vectors++;
      if (!ok || d !== -1) begin miscompares++; $display("FAIL rnd%0d_trace: ok=%b bad entry %0d, want 1/-1", j, ok, d); end
      sp = min_byte_space(k0);
      vectors++;
      if (sp < 2 + BYTE_GAP) begin miscompares++; $display("FAIL rnd%0d_spacing: got %0d, want >= %0d", j, sp, 2 + BYTE_GAP); end
      exp_last = crc_model(ps ? p : POLY_DEF, c, b);
      vectors++;
      if (result !== exp_last || rv_count - rv0 != 1 || timeout_err !== 1'b0) begin
        miscompares++;
        $display("FAIL rnd%0d_result: got %h pulses %0d err=%b, want %h pulses 1 err=0", j, result, rv_count - rv0, timeout_err, exp_last);
      end
    end
    noise_en = 1'b0;
    stall_cycles = 0;
  endtask

  task automatic test_protocol();
    vectors++;
    if (proto_err != 0) begin
      miscompares++;
      $display("FAIL bus_protocol: got %0d violations, want 0", proto_err);
    end
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    test_known_vector();
    test_backpressure();
    test_read_stall();
    test_timeout();
    test_reset_mid();
    test_random();
    test_protocol();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
